// File: rtl/updown_counter_ctrl_if.sv
// Wishbone slave bus bundle between user_project_wrapper and the
// up/down counter controller.
interface updown_counter_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/updown_counter_ctrl.sv
// Wishbone-configured sequencer for the up/down counter: prescaled tick,
// direction selection (manual/up/down/ping-pong), clear and match interrupt.
module updown_counter_ctrl #(
  parameter int                 WIDTH        = 4,
  parameter int                 PRE_W        = 16,
  parameter logic [PRE_W-1:0]   PRESCALE_RST = {PRE_W{1'b1}}
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  updown_counter_ctrl_if.slave wbs,
  input  logic                 up_down_pin,
  input  logic [WIDTH-1:0]     counter_in,
  output logic                 ctr_tick,
  output logic                 ctr_up_down,
  output logic                 ctr_clr,
  output logic                 irq
);

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d, rdata;
  logic             en_q, en_d, irq_en_q, irq_en_d;
  logic [1:0]       mode_q, mode_d;
  logic [PRE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             match_q, match_d, irq_q, irq_d;
  dir_e             dir_q, dir_d;
  logic             pin_s1_q, pin_s1_d, pin_s2_q, pin_s2_d;
  logic             tick_q, tick_d, tick_dly_q, tick_dly_d;
  logic             clr_q, clr_d, ud_q, ud_d;
  logic             req, wr, wr_ctrl, wr_pre, wr_lim, wr_stat, clr_req, expire;
  logic             unused_ok;

  assign unused_ok = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0],
                       wbs.wbs_dat_i[31:PRE_W]};

  always_comb begin
    rdata = '0;
    case (wbs.wbs_adr_i[3:2])
      2'd0:    rdata[4:0] = {irq_en_q, 1'b0, mode_q, en_q};
      2'd1:    rdata[PRE_W-1:0] = prescale_q;
      2'd2:    rdata[WIDTH-1:0] = limit_q;
      default: begin
        rdata[0]         = match_q;
        rdata[1]         = dir_q;
        rdata[8+:WIDTH]  = counter_in;
      end
    endcase
  end

  always_comb begin
    req     = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
    wr      = req & wbs.wbs_we_i;
    wr_ctrl = wr & (wbs.wbs_adr_i[3:2] == 2'd0);
    wr_pre  = wr & (wbs.wbs_adr_i[3:2] == 2'd1);
    wr_lim  = wr & (wbs.wbs_adr_i[3:2] == 2'd2);
    wr_stat = wr & (wbs.wbs_adr_i[3:2] == 2'd3);
    clr_req = wr_ctrl & wbs.wbs_dat_i[3];
    // A write that drops en also kills an expiry landing on the same edge.
    expire  = en_q & (pcnt_q == prescale_q) & ~(wr_ctrl & ~wbs.wbs_dat_i[0]);

    ack_d      = req;
    dat_d      = (req & ~wbs.wbs_we_i) ? rdata : 32'd0;
    en_d       = wr_ctrl ? wbs.wbs_dat_i[0]   : en_q;
    mode_d     = wr_ctrl ? wbs.wbs_dat_i[2:1] : mode_q;
    irq_en_d   = wr_ctrl ? wbs.wbs_dat_i[4]   : irq_en_q;
    prescale_d = wr_pre  ? wbs.wbs_dat_i[PRE_W-1:0] : prescale_q;
    limit_d    = wr_lim  ? wbs.wbs_dat_i[WIDTH-1:0] : limit_q;

    if (!en_q || wr_pre || clr_req || pcnt_q == prescale_q) pcnt_d = '0;
    else                                                   pcnt_d = pcnt_q + 1'b1;

    pin_s1_d = up_down_pin;
    pin_s2_d = pin_s1_q;
    tick_d   = 1'b0;
    clr_d    = clr_req;
    dir_d    = dir_q;
    ud_d     = (mode_q == 2'd0) ? pin_s2_q : ud_q;

    if (expire) begin
      case (mode_q)
        2'd0: tick_d = 1'b1;
        2'd1: begin tick_d = 1'b1; ud_d = 1'b1; end
        2'd2: begin tick_d = 1'b1; ud_d = 1'b0; end
        default: if (limit_q != '0) begin
          if (dir_q == DIR_UP && counter_in >= limit_q)  dir_d = DIR_DOWN;
          else if (dir_q == DIR_DOWN && counter_in == '0) dir_d = DIR_UP;
          tick_d = 1'b1;
          ud_d   = (dir_d == DIR_UP);
        end
      endcase
    end

    if (clr_req) begin
      tick_d = 1'b0;
      dir_d  = DIR_UP;
    end

    // Compare one cycle after the tick, once the counter has stepped.
    tick_dly_d = tick_q;
    match_d    = (tick_dly_q & (counter_in == limit_q)) |
                 (match_q & ~(wr_stat & wbs.wbs_dat_i[0]));
    irq_d      = match_q & irq_en_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      en_q       <= 1'b0;
      mode_q     <= 2'd0;
      irq_en_q   <= 1'b0;
      prescale_q <= PRESCALE_RST;
      limit_q    <= '1;
      pcnt_q     <= '0;
      pin_s1_q   <= 1'b0;
      pin_s2_q   <= 1'b0;
      tick_q     <= 1'b0;
      tick_dly_q <= 1'b0;
      clr_q      <= 1'b0;
      ud_q       <= 1'b1;
      dir_q      <= DIR_UP;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      limit_q    <= limit_d;
      pcnt_q     <= pcnt_d;
      pin_s1_q   <= pin_s1_d;
      pin_s2_q   <= pin_s2_d;
      tick_q     <= tick_d;
      tick_dly_q <= tick_dly_d;
      clr_q      <= clr_d;
      ud_q       <= ud_d;
      dir_q      <= dir_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign ctr_tick      = tick_q;
  assign ctr_up_down   = ud_q;
  assign ctr_clr       = clr_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Directed bench for updown_counter_ctrl: register table plus multi-cycle
// sequences against a behavioural 4-bit up/down counter.
module tb_updown_counter_ctrl;
  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       up_down_pin = 1'b0;
  logic [3:0] cnt_m = 4'd0;
  logic       ctr_tick, ctr_up_down, ctr_clr, irq;
  int         checks = 0;
  int         errors = 0;
  int         tick_cnt = 0;

  updown_counter_ctrl_if wbs ();

  updown_counter_ctrl dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs         (wbs),
    .up_down_pin (up_down_pin),
    .counter_in  (cnt_m),
    .ctr_tick    (ctr_tick),
    .ctr_up_down (ctr_up_down),
    .ctr_clr     (ctr_clr),
    .irq         (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // the counter being controlled
  always @(posedge wb_clk_i) begin
    if (ctr_clr)       cnt_m <= 4'd0;
    else if (ctr_tick) cnt_m <= ctr_up_down ? cnt_m + 4'd1 : cnt_m - 4'd1;
  end

  always @(negedge wb_clk_i) if (ctr_tick) tick_cnt++;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      output logic [31:0] rd);
    int k;
    @(posedge wb_clk_i); #1;
    wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1; wbs.wbs_we_i = we;
    wbs.wbs_adr_i = adr;  wbs.wbs_dat_i = dat;
    k = 0;
    do begin
      @(posedge wb_clk_i); #1;
      k++;
    end while (!wbs.wbs_ack_o && k < 4);
    rd = wbs.wbs_dat_o;
    if (!wbs.wbs_ack_o) begin
      checks++; errors++;
      $display("FAIL bus_ack: no ack for adr %h within 4 cycles", adr);
    end
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    xfer(1'b1, adr, dat, d);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    xfer(1'b0, adr, 32'd0, d);
  endtask

  // returns at the negedge inside the next tick cycle
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!ctr_tick && n < 40);
    if (!ctr_tick) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no ctr_tick within 40 cycles");
    end
  endtask

  logic [31:0] d;
  int          n;
  int          t0;
  logic [3:0]  pp_cnt [12];
  logic        pp_ud  [12];

  initial begin
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
    wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = '0;   wbs.wbs_dat_i = '0;

    vecs[0]  = '{1'b0, 32'h0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 32'h4, 32'h0,        32'h0000FFFF};
    vecs[2]  = '{1'b0, 32'h8, 32'h0,        32'h0000000F};
    vecs[3]  = '{1'b0, 32'hC, 32'h0,        32'h00000002};
    vecs[4]  = '{1'b1, 32'h0, 32'hFFFFFFFE, 32'h0};
    vecs[5]  = '{1'b0, 32'h0, 32'h0,        32'h00000016};
    vecs[6]  = '{1'b1, 32'h4, 32'hABCD1234, 32'h0};
    vecs[7]  = '{1'b0, 32'h4, 32'h0,        32'h00001234};
    vecs[8]  = '{1'b1, 32'h8, 32'hFFFFFFF5, 32'h0};
    vecs[9]  = '{1'b0, 32'h8, 32'h0,        32'h00000005};
    vecs[10] = '{1'b1, 32'h0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 32'hC, 32'h0,        32'h00000002};

    pp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2};
    pp_ud  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // reset state and register table
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("reset_outputs", {29'd0, ctr_tick, ctr_clr, ctr_up_down}, 32'd1);
    chk("reset_ack_dat_irq", {wbs.wbs_dat_o[30:0], wbs.wbs_ack_o}, 32'd0);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, d);
      if (!vecs[i].we) chk($sformatf("reg_vec%0d", i), d, vecs[i].exp);
    end
    chk("no_tick_while_disabled", tick_cnt, 0);
    chk("irq_idle", {31'd0, irq}, 32'd0);

    // fixed up, PRESCALE=3: one tick every 4 cycles, wraps 15->0
    wr(32'h4, 32'd3);
    wr(32'h0, 32'h8);
    wr(32'h0, 32'h3);
    for (int i = 0; i < 17; i++) begin
      wait_tick(n);
      if (i > 0) chk($sformatf("up_period%0d", i), n, 4);
      chk($sformatf("up_dir%0d", i), {31'd0, ctr_up_down}, 32'd1);
    end
    @(posedge wb_clk_i); #1;
    chk("up_wrap", {28'd0, cnt_m}, 32'd1);

    // ping-pong between 0 and LIMIT=5
    wr(32'h0, 32'h8);
    wr(32'h8, 32'd5);
    wr(32'h0, 32'h7);
    for (int i = 0; i < 12; i++) begin
      wait_tick(n);
      chk($sformatf("pp_ud%0d", i), {31'd0, ctr_up_down}, {31'd0, pp_ud[i]});
      @(posedge wb_clk_i); #1;
      chk($sformatf("pp_cnt%0d", i), {28'd0, cnt_m}, {28'd0, pp_cnt[i]});
      if (i == 5) begin rd(32'hC, d); chk("pp_status_dir_down", {31'd0, d[1]}, 32'd0); end
      if (i == 10) begin rd(32'hC, d); chk("pp_status_dir_up", {31'd0, d[1]}, 32'd1); end
    end

    // match / irq, W1C, and W1C colliding with a new match
    wr(32'h8, 32'd9);
    wr(32'h0, 32'h8);
    wr(32'hC, 32'h1);
    wr(32'h0, 32'h13);
    for (int i = 0; i < 9; i++) wait_tick(n);
    repeat (4) @(posedge wb_clk_i);
    #1;
    chk("match_irq_set", {31'd0, irq}, 32'd1);
    rd(32'hC, d);
    chk("match_status_set", {30'd0, d[1:0]}, 32'd3);
    wr(32'hC, 32'h1);
    repeat (2) @(posedge wb_clk_i);
    #1;
    chk("match_irq_cleared", {31'd0, irq}, 32'd0);
    rd(32'hC, d);
    chk("match_status_cleared", {31'd0, d[0]}, 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      wait_tick(t0);
      if (cnt_m == 4'd8 && ctr_up_down) begin n = 1; break; end
    end
    chk("match_collide_reached8", n, 1);
    wr(32'hC, 32'h1);
    rd(32'hC, d);
    chk("match_set_beats_w1c", {31'd0, d[0]}, 32'd1);

    // manual direction via the synchronised pin
    wr(32'h0, 32'h8);
    wr(32'h0, 32'h1);
    up_down_pin = 1'b0;
    repeat (5) @(posedge wb_clk_i);
    #1;
    chk("pin_low", {31'd0, ctr_up_down}, 32'd0);
    up_down_pin = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("pin_not_yet", {31'd0, ctr_up_down}, 32'd0);
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("pin_high", {31'd0, ctr_up_down}, 32'd1);

    // clear landing on the edge that would issue a tick
    wait_tick(n);
    repeat (2) @(posedge wb_clk_i);
    t0 = tick_cnt;
    wr(32'h0, 32'h9);
    chk("clr_pulse_no_tick", {30'd0, ctr_clr, ctr_tick}, 32'd2);
    @(posedge wb_clk_i); #1;
    chk("clr_counter_zero", {28'd0, cnt_m}, 32'd0);
    chk("clr_pulse_width", {31'd0, ctr_clr}, 32'd0);
    repeat (2) @(posedge wb_clk_i);
    #1;
    chk("clr_tick_suppressed", tick_cnt, t0);

    // reset mid ping-pong with the counter at 3 going down
    wr(32'h0, 32'h8);
    wr(32'h8, 32'd5);
    wr(32'h0, 32'h17);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      wait_tick(t0);
      @(posedge wb_clk_i); #1;
      if (cnt_m == 4'd3 && !ctr_up_down) begin n = 1; break; end
    end
    chk("rst_reached3down", n, 1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("rst_outputs", {28'd0, ctr_tick, ctr_clr, ctr_up_down, irq}, 32'h2);
    chk("rst_bus", {wbs.wbs_dat_o[30:0], wbs.wbs_ack_o}, 32'd0);
    wb_rst_i = 1'b0;
    rd(32'hC, d);
    chk("rst_status", {30'd0, d[1:0]}, 32'd2);
    rd(32'h0, d);
    chk("rst_ctrl", d, 32'd0);
    rd(32'h4, d);
    chk("rst_prescale", d, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/updown_counter_ctrl.md
Name: updown_counter_ctrl

Overview:
Wishbone-configured controller that sequences the 4-bit up/down counter in the user project area. It generates a prescaled count-enable tick, drives the counter's direction (manual pin, fixed up, fixed down, or ping-pong between 0 and LIMIT), issues synchronous clears, and raises a sticky match interrupt. It sits between the Wishbone slave port of user_project_wrapper and the counter instance.

Parameters:
WIDTH, 4, counter width; also the width of counter_in and LIMIT.
PRE_W, 16, prescaler width.
PRESCALE_RST, 16'hFFFF, reset value of the PRESCALE register.

Ports:
wb_clk_i  input  1  sole clock
wb_rst_i  input  1  synchronous reset, active-high
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte selects; ignored, all writes are full-word
wbs_adr_i  input  32  address; only [3:2] decoded
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
up_down_pin  input  1  external direction pin, asynchronous to wb_clk_i
counter_in  input  WIDTH  current counter value
ctr_tick  output  1  count enable; the counter steps on an edge where ctr_tick=1
ctr_up_down  output  1  direction to counter; 1=up, 0=down
ctr_clr  output  1  synchronous clear pulse to counter
irq  output  1  match interrupt, level

Behaviour:
- Reset state: ack=0, dat_o=0, ctr_tick=0, ctr_clr=0, ctr_up_down=1, irq=0. CTRL=0, PRESCALE=PRESCALE_RST, LIMIT=all ones, match=0, dir=UP, prescaler count=0, sync flops=0.
- Registers, decoded by adr[3:2]:
  0 CTRL: [0] en, [2:1] mode (0 manual, 1 up, 2 down, 3 ping-pong), [3] clr (write-1 pulse, reads 0), [4] irq_en.
  1 PRESCALE: [PRE_W-1:0].
  2 LIMIT: [WIDTH-1:0].
  3 STATUS: [0] match (write 1 to clear), [1] dir, [8+WIDTH-1:8] counter_in; all other bits read-only.
  Unused bits read 0.
- Bus: when stb&cyc&!ack, ack=1 for exactly one cycle on the next edge. Writes take effect on that same edge. dat_o is registered with ack and is 0 whenever ack=0. Back-to-back requests are acknowledged every other cycle.
- Prescaler:
  - en=0: prescaler count held at 0 and no ticks are issued.
  - en=1: the count increments each cycle. When count==PRESCALE, the count returns to 0 and a tick is issued. This gives one tick every PRESCALE+1 cycles; PRESCALE=0 ticks every cycle.
  - Any PRESCALE write resets the count to 0.
  - ctr_tick is registered: high for one cycle, on the cycle after the expiry is detected.
- Direction, registered into ctr_up_down together with the tick:
  - mode0: two-flop synchronised up_down_pin, updated every cycle.
  - mode1: 1. mode2: 0. Natural wrap at 0 and 2^WIDTH-1 is left to the counter.
  - mode3 (ping-pong), evaluated at each expiry:
    - dir=UP and counter_in>=LIMIT: dir<=DOWN and the tick is issued with down.
    - dir=DOWN and counter_in==0: dir<=UP and the tick is issued with up.
    - LIMIT==0: no ticks are issued.
- Clear: a CTRL write with bit3=1 gives ctr_clr=1 for one cycle, prescaler count=0, and dir=UP. A clear and a tick in the same cycle: the clear wins and the tick is suppressed.
- Match: set in the cycle after a tick when counter_in==LIMIT. If set and W1C occur in the same cycle, set wins. irq = match & irq_en, registered.
- Mode change: takes effect at the next expiry; dir keeps its value.
- Disabling en mid-period: no tick is issued after the write edge.
- Reset mid-operation: everything returns to the reset state on the next edge.

Test Plan:
1. Reset, then read all registers -> CTRL=0, PRESCALE=0xFFFF, LIMIT=0xF, STATUS[0]=0, ctr_up_down=1, ctr_tick never asserted.
2. PRESCALE=3, CTRL=0x3 (en, up) -> ctr_tick one cycle every 4 cycles, ctr_up_down=1; counter 0..15 wraps to 0.
3. LIMIT=5, CTRL=0x7 (ping-pong) -> counter sequence 0,1,2,3,4,5,4,3,2,1,0,1…; STATUS[1] toggles at 5 and 0.
4. LIMIT=9, irq_en, mode1, counter reaches 9 -> STATUS[0]=1, irq=1; W1C on STATUS clears irq. W1C coinciding with a new match -> match stays 1.
5. Mode0, toggle up_down_pin -> ctr_up_down follows after 2–3 cycles. Write CTRL clr during a tick cycle -> ctr_clr=1, no tick, counter=0.
6. Assert wb_rst_i mid-ping-pong with the counter at 3 going down -> all outputs at reset values on the next edge, dir=UP.
